// File: rtl/ama_riscv_hazard_ctrl.sv
// Hazard sequencing for the 5-stage pipeline: load-use bubble, DMEM freeze with
// timeout, and the two-cycle IF/ID flush that follows an EX redirect.
module ama_riscv_hazard_ctrl #(
   parameter int STALL_CNT_W = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   inst_valid_id,
   input  logic                   rs1_used_id,
   input  logic                   rs2_used_id,
   input  logic [4:0]             rs1_id,
   input  logic [4:0]             rs2_id,
   input  logic                   load_inst_ex,
   input  logic [4:0]             rd_ex,
   input  logic                   dmem_req_mem,
   input  logic                   dmem_ready,
   input  logic                   branch_taken_ex,
   output logic                   stall_if,
   output logic                   stall_id,
   output logic                   stall_ex,
   output logic                   stall_mem,
   output logic                   bubble_ex,
   output logic                   flush_if,
   output logic                   flush_id,
   output logic                   pc_redirect,
   output logic [1:0]             state,
   output logic [STALL_CNT_W-1:0] stall_cycles,
   output logic                   err_mem_timeout
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(MEM_TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

   state_t                 state_q, state_d;
   logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
   logic                   err_q, err_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic freeze, lu;
   logic stall_if_c, stall_id_c, stall_ex_c, stall_mem_c;
   logic bubble_ex_c, flush_if_c, flush_id_c, pc_redirect_c;

   assign freeze = dmem_req_mem && !dmem_ready;
   assign lu     = load_inst_ex && inst_valid_id && (rd_ex != 5'd0) &&
                   ((rs1_used_id && (rs1_id == rd_ex)) ||
                    (rs2_used_id && (rs2_id == rd_ex)));

   always_comb begin
      state_d       = state_q;
      stall_if_c    = 1'b0;
      stall_id_c    = 1'b0;
      stall_ex_c    = 1'b0;
      stall_mem_c   = 1'b0;
      bubble_ex_c   = 1'b0;
      flush_if_c    = 1'b0;
      flush_id_c    = 1'b0;
      pc_redirect_c = 1'b0;

      if (freeze) begin
         stall_if_c  = 1'b1;
         stall_id_c  = 1'b1;
         stall_ex_c  = 1'b1;
         stall_mem_c = 1'b1;
         if (state_q == RUN)
            state_d = MEM_WAIT;
      end else begin
         case (state_q)
            RUN, MEM_WAIT: begin
               // Redirect wins over load-use: the dependent ID instruction is flushed anyway.
               if (branch_taken_ex) begin
                  pc_redirect_c = 1'b1;
                  flush_if_c    = 1'b1;
                  flush_id_c    = 1'b1;
                  state_d       = FLUSH;
               end else begin
                  if (lu) begin
                     stall_if_c  = 1'b1;
                     stall_id_c  = 1'b1;
                     bubble_ex_c = 1'b1;
                  end
                  state_d = RUN;
               end
            end
            FLUSH: begin
               flush_id_c = 1'b1;
               state_d    = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_comb begin
      tmo_cnt_d = '0;
      err_d     = err_q;
      if (freeze) begin
         tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
         if (tmo_cnt_q >= TMO_LAST)
            err_d = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_if_c && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         tmo_cnt_q   <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         tmo_cnt_q   <= tmo_cnt_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Controls are combinational, so gate them with reset to keep them quiet while rst_n is low.
   assign stall_if        = rst_n & stall_if_c;
   assign stall_id        = rst_n & stall_id_c;
   assign stall_ex        = rst_n & stall_ex_c;
   assign stall_mem       = rst_n & stall_mem_c;
   assign bubble_ex       = rst_n & bubble_ex_c;
   assign flush_if        = rst_n & flush_if_c;
   assign flush_id        = rst_n & flush_id_c;
   assign pc_redirect     = rst_n & pc_redirect_c;
   assign state           = state_q;
   assign stall_cycles    = stall_cnt_q;
   assign err_mem_timeout = err_q;

endmodule

// File: tb/tb_ama_riscv_hazard_ctrl.sv
// Directed bench for ama_riscv_hazard_ctrl with hand-computed control vectors.
module tb_ama_riscv_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inst_valid_id, rs1_used_id, rs2_used_id;
   logic [4:0]  rs1_id, rs2_id, rd_ex;
   logic        load_inst_ex, dmem_req_mem, dmem_ready, branch_taken_ex;
   logic        stall_if, stall_id, stall_ex, stall_mem;
   logic        bubble_ex, flush_if, flush_id, pc_redirect;
   logic [1:0]  state;
   logic [15:0] stall_cycles;
   logic        err_mem_timeout;

   int n_tests = 0;
   int n_fail  = 0;

   // Control vector order: stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_if, flush_id, pc_redirect
   localparam logic [7:0] C_NONE   = 8'b0000_0000;
   localparam logic [7:0] C_LU     = 8'b1100_1000;
   localparam logic [7:0] C_FREEZE = 8'b1111_0000;
   localparam logic [7:0] C_REDIR  = 8'b0000_0111;
   localparam logic [7:0] C_FLUSH  = 8'b0000_0010;

   ama_riscv_hazard_ctrl #(.STALL_CNT_W(16), .MEM_TIMEOUT(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .inst_valid_id   (inst_valid_id),
      .rs1_used_id     (rs1_used_id),
      .rs2_used_id     (rs2_used_id),
      .rs1_id          (rs1_id),
      .rs2_id          (rs2_id),
      .load_inst_ex    (load_inst_ex),
      .rd_ex           (rd_ex),
      .dmem_req_mem    (dmem_req_mem),
      .dmem_ready      (dmem_ready),
      .branch_taken_ex (branch_taken_ex),
      .stall_if        (stall_if),
      .stall_id        (stall_id),
      .stall_ex        (stall_ex),
      .stall_mem       (stall_mem),
      .bubble_ex       (bubble_ex),
      .flush_if        (flush_if),
      .flush_id        (flush_id),
      .pc_redirect     (pc_redirect),
      .state           (state),
      .stall_cycles    (stall_cycles),
      .err_mem_timeout (err_mem_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ctrl();
      return {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_if, flush_id, pc_redirect};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] c, input logic [1:0] st);
      check({tag, ".ctrl"}, {24'd0, ctrl()}, {24'd0, c});
      check({tag, ".state"}, {30'd0, state}, {30'd0, st});
      $display("[TB] %s ctrl=%b state=%0d stall_cycles=%0d err=%0b",
               tag, ctrl(), state, stall_cycles, err_mem_timeout);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      inst_valid_id = 0; rs1_used_id = 0; rs2_used_id = 0;
      rs1_id = 0; rs2_id = 0; rd_ex = 0; load_inst_ex = 0;
      dmem_req_mem = 0; dmem_ready = 0; branch_taken_ex = 0;
   endtask

   task automatic set_lu_rs1();
      load_inst_ex = 1; rd_ex = 5; rs1_id = 5; rs1_used_id = 1; inst_valid_id = 1;
   endtask

   initial begin
      clear_inputs();
      rst_n = 0;
      #12;
      chk("reset", C_NONE, 2'd0);
      check("reset.stall_cycles", {16'd0, stall_cycles}, 32'd0);
      check("reset.err", {31'd0, err_mem_timeout}, 32'd0);
      rst_n = 1;
      tick();

      // Load-use on rs1
      set_lu_rs1(); #1;
      chk("lu_rs1", C_LU, 2'd0);
      tick(); clear_inputs(); #1;
      chk("lu_rs1_after", C_NONE, 2'd0);
      check("lu_rs1.stall_cycles", {16'd0, stall_cycles}, 32'd1);

      set_lu_rs1(); rd_ex = 0; rs1_id = 0; #1;
      chk("lu_rd0", C_NONE, 2'd0);
      set_lu_rs1(); rs1_used_id = 0; #1;
      chk("lu_rs1_unused", C_NONE, 2'd0);
      clear_inputs();
      load_inst_ex = 1; inst_valid_id = 1; rd_ex = 7; rs2_id = 7; rs2_used_id = 1; #1;
      chk("lu_rs2", C_LU, 2'd0);
      tick(); clear_inputs(); #1;
      check("lu_rs2.stall_cycles", {16'd0, stall_cycles}, 32'd2);

      // Redirect: RUN flush cycle, FLUSH cycle, back to RUN
      branch_taken_ex = 1; #1;
      chk("redir_c0", C_REDIR, 2'd0);
      tick(); branch_taken_ex = 0; #1;
      chk("redir_c1", C_FLUSH, 2'd2);
      tick();
      chk("redir_c2", C_NONE, 2'd0);

      // Branch together with load-use; load-use also held during FLUSH
      branch_taken_ex = 1; set_lu_rs1(); #1;
      chk("br_lu_c0", C_REDIR, 2'd0);
      tick(); #1;
      chk("br_lu_c1", C_FLUSH, 2'd2);
      tick(); clear_inputs(); #1;
      chk("br_lu_c2", C_NONE, 2'd0);

      // Clear the stall counter with a short asynchronous reset pulse
      rst_n = 0; #2; rst_n = 1; #1;
      check("rst_pulse.stall_cycles", {16'd0, stall_cycles}, 32'd0);

      // DMEM wait with a pending branch
      dmem_req_mem = 1; dmem_ready = 0; branch_taken_ex = 1; #1;
      chk("dmem_w1", C_FREEZE, 2'd0);
      tick();
      chk("dmem_w2", C_FREEZE, 2'd1);
      tick();
      chk("dmem_w3", C_FREEZE, 2'd1);
      tick(); dmem_ready = 1; #1;
      chk("dmem_ready", C_REDIR, 2'd1);
      check("dmem.stall_cycles", {16'd0, stall_cycles}, 32'd3);
      tick(); clear_inputs(); #1;
      chk("dmem_flush", C_FLUSH, 2'd2);
      tick();
      chk("dmem_run", C_NONE, 2'd0);

      // Freeze arriving while in FLUSH holds FLUSH and suppresses flush_id
      branch_taken_ex = 1;
      tick(); clear_inputs(); dmem_req_mem = 1; #1;
      chk("flush_frz0", C_FREEZE, 2'd2);
      tick();
      chk("flush_frz1", C_FREEZE, 2'd2);
      dmem_ready = 1; #1;
      chk("flush_rel", C_FLUSH, 2'd2);
      tick(); clear_inputs(); #1;
      chk("flush_done", C_NONE, 2'd0);

      // Timeout with MEM_TIMEOUT=4: flag rises on the edge after the 4th freeze cycle
      dmem_req_mem = 1; dmem_ready = 0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check($sformatf("tmo_edge%0d.err", i), {31'd0, err_mem_timeout}, 32'd0);
      end
      tick();
      check("tmo_edge4.err", {31'd0, err_mem_timeout}, 32'd1);
      chk("tmo_state", C_FREEZE, 2'd1);
      dmem_ready = 1; #1;
      chk("tmo_ready", C_NONE, 2'd1);
      tick(); clear_inputs(); #1;
      chk("tmo_after", C_NONE, 2'd0);
      check("tmo_sticky.err", {31'd0, err_mem_timeout}, 32'd1);

      // Asynchronous reset in MEM_WAIT
      dmem_req_mem = 1; dmem_ready = 0;
      tick();
      check("pre_rst_mw.state", {30'd0, state}, 32'd1);
      rst_n = 0; #1;
      chk("rst_mw", C_NONE, 2'd0);
      check("rst_mw.stall_cycles", {16'd0, stall_cycles}, 32'd0);
      check("rst_mw.err", {31'd0, err_mem_timeout}, 32'd0);
      clear_inputs(); rst_n = 1;
      tick();

      // Asynchronous reset in FLUSH: no pending redirect survives
      branch_taken_ex = 1;
      tick(); branch_taken_ex = 0; #1;
      check("pre_rst_fl.state", {30'd0, state}, 32'd2);
      rst_n = 0; #1;
      chk("rst_fl", C_NONE, 2'd0);
      rst_n = 1;
      tick();
      chk("rst_fl_after", C_NONE, 2'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required=<20000", $time);
      $fatal(1, "watchdog");
   end

endmodule
